fp_multiplier: RTL and testbench
================================

// Module: fp_multiplier
// PURPOSE
//   Multi-cycle IEEE-754 single-precision multiplier for the Newton-Raphson datapath.
//   Computes the x_n*d and x_n*(2-d*x_n) products that feed the adder stage.
//   Takes one operand pair per input_stb pulse and returns the rounded product with a one-cycle output_z_stb.
//   Output port naming and strobe semantics match the adder so the two chain directly.
// PARAMETERS
//   FLUSH_DENORM  0  1: denormal inputs read as signed zero and denormal results flush to signed zero.
// PORTS
//   clk           in   1   rising-edge clock
//   rst           in   1   asynchronous, active-low reset
//   input_stb     in   1   operand-valid pulse; sampled only in IDLE
//   input_a       in   32  operand A, IEEE-754 single
//   input_b       in   32  operand B, IEEE-754 single
//   output_z      out  32  product; held until the next result
//   output_z_stb  out  1   one-cycle pulse, output_z valid
//   busy          out  1   high from the cycle after capture until the strobe cycle inclusive
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE, output_z=0, output_z_stb=0, busy=0, all internal registers cleared.
//   Reset mid-operation aborts the operation: no strobe is issued, and the first post-reset input_stb starts fresh.
//   FSM, one cycle per state unless noted:
//     IDLE -> UNPACK -> SPECIAL -> NORM_A -> NORM_B -> MUL_0 -> MUL_1 -> NORM_1 -> NORM_2 -> ROUND -> PACK -> OUT -> IDLE
//   IDLE: input_stb=1 captures input_a/input_b. input_stb in any other state is ignored (no queueing).
//   UNPACK: split sign/exponent/mantissa, exponent = e-127.
//     Denormal (e=0): exponent = -126 and the hidden bit is 0. Otherwise the hidden bit is 1.
//   SPECIAL: goes straight to OUT with:
//     - NaN in, or inf*0 -> 32'h7fc00000.
//     - inf in -> {sa^sb, 8'hff, 23'b0}.
//     - zero in -> {sa^sb, 31'b0}.
//   NORM_A/NORM_B: while the hidden bit is 0, shift the mantissa left and decrement the exponent. Each shift costs 1 extra cycle.
//   MUL_0: 24x24 -> 48-bit product; sign = sa^sb; exponent = ea+eb+1.
//   MUL_1: take the top 24 bits as the mantissa, plus guard (bit 23), round (bit 22) and sticky (OR of bits 21:0).
//   NORM_1: while mantissa[23]=0, shift left through guard and decrement the exponent. Normal*normal needs at most 1 shift.
//   NORM_2: while exponent < -126, shift right, increment the exponent and fold the shifted-out bits into sticky.
//   ROUND: round to nearest, ties to even: increment if guard & (round | sticky | m[0]).
//     Mantissa carry-out (24'hffffff+1) increments the exponent.
//   PACK:
//     - exponent > 127 -> signed inf.
//     - exponent = -126 with m[23]=0 -> denormal encoding (e=0).
//     - Otherwise e = exponent+127.
//   OUT: drive output_z, output_z_stb=1 for exactly this cycle; busy drops the next cycle.
//   Latency, counted from the edge at which input_stb was sampled to output_z_stb high:
//     - 11 clocks for normal operands with a normal result.
//     - 3 clocks for special cases.
//     - +1 per denormal normalise or underflow shift.
//   Back-to-back operation: a new input_stb is accepted the first cycle busy=0. Minimum issue interval is 12 clocks.
// STRUCTURE
//   Shared package fp32_pkg:
//     - field widths: EXP_W=8, MAN_W=23
//     - BIAS=127, EMIN=-126, EMAX=127
//     - QNAN=32'h7fc00000, POS_INF=32'h7f800000
//     - FSM state encoding (reused by the adder)
//   Sub-module fp32_round_pack: ROUND+PACK combinational core (mantissa, exponent, sign, G/R/S in -> 32-bit word out).
//     Written for reuse by the adder.
//   The FSM, unpack and multiply logic stay in fp_multiplier.
// TESTING
//   1. 40000000 x 40400000 (2*3): output_z=40c00000, strobe 11 clocks after input_stb, busy low next cycle.
//   2. bfc00000 x 40800000 -> c0c00000; 3f800001 x 3f800001 -> 3f800002 (round to nearest even).
//   3. 7f800000 x 00000000 -> 7fc00000 with a 3-clock strobe; ff800000 x 40000000 -> ff800000.
//   4. 7f7fffff x 40000000 -> 7f800000 (overflow to inf); 00800000 x 3f000000 -> 00400000 (denormal result).
//   5. 00000001 x 4b000000, FLUSH_DENORM=0 -> 00800000 after 23 extra cycles. Same pair with FLUSH_DENORM=1 -> 00000000.
//   6. Drop rst for 1 cycle 5 clocks into 40400000 x 3f000000: outputs zero, no strobe.
//      Re-issue the same pair: output_z=3fc00000. An input_stb pulse while busy is ignored.

Source files
------------

// File: rtl/fp32_pkg.sv
// ----------------------------------------------------------------------------
// fp32_pkg
//   Shared definitions for the IEEE-754 single-precision arithmetic units
//   (multiplier and adder): field widths, exponent limits, special encodings,
//   the common FSM state encoding and an exponent unbias helper.
//   Internal exponents are carried as 10-bit signed values so that the
//   unnormalised range of a product (about -298 .. +255) fits without wrap.
// ----------------------------------------------------------------------------
package fp32_pkg;

   localparam int EXP_W  = 8;
   localparam int MAN_W  = 23;
   localparam int EXP_IW = 10;

   typedef logic signed [EXP_IW-1:0] exp_t;

   localparam exp_t BIAS = 10'sd127;
   localparam exp_t EMIN = -10'sd126;
   localparam exp_t EMAX = 10'sd127;

   localparam logic [31:0] QNAN    = 32'h7fc00000;
   localparam logic [31:0] POS_INF = 32'h7f800000;

   typedef enum logic [3:0] {
      IDLE,
      UNPACK,
      SPECIAL,
      NORM_A,
      NORM_B,
      MUL_0,
      MUL_1,
      NORM_1,
      NORM_2,
      ROUND,
      PACK,
      OUT
   } state_t;

   // Biased exponent field -> true exponent; denormals sit at EMIN.
   function automatic exp_t unbias(input logic [EXP_W-1:0] e);
      return (e == '0) ? EMIN : ($signed({2'b00, e}) - BIAS);
   endfunction

endpackage

// File: rtl/fp32_round_pack.sv
// ----------------------------------------------------------------------------
// fp32_round_pack
//   Combinational round-to-nearest-even and pack core.
//   Ports:
//     man        in  24  normalised mantissa (bit 23 = hidden bit)
//     exp_in     in  10  signed true exponent, >= EMIN
//     sign       in  1   result sign
//     guard      in  1   first bit below the mantissa LSB
//     round_bit  in  1   second bit below the mantissa LSB
//     sticky     in  1   OR of every bit below round_bit
//     z          out 32  packed IEEE-754 single word
//   FLUSH_DENORM=1 replaces a denormal encoding with a signed zero.
// ----------------------------------------------------------------------------
module fp32_round_pack
   import fp32_pkg::*;
#(
   parameter int FLUSH_DENORM = 0
)(
   input  logic               [23:0] man,
   input  logic signed [EXP_IW-1:0] exp_in,
   input  logic                      sign,
   input  logic                      guard,
   input  logic                      round_bit,
   input  logic                      sticky,
   output logic               [31:0] z
);

   logic        inc;
   logic [24:0] sum;
   logic [23:0] man_r;
   exp_t        exp_r;

   always_comb begin
      inc   = guard & (round_bit | sticky | man[0]);
      sum   = {1'b0, man} + {24'b0, inc};
      man_r = sum[23:0];
      exp_r = exp_in;
      // 24'hffffff + 1 carries out: renormalise to 1.0 and bump the exponent.
      if (sum[24]) begin
         man_r = sum[24:1];
         exp_r = exp_in + 10'sd1;
      end

      if (exp_r > EMAX) begin
         z = {sign, POS_INF[30:0]};
      end else if ((exp_r == EMIN) && !man_r[23]) begin
         // No hidden bit at the minimum exponent: denormal (or zero) encoding.
         z = (FLUSH_DENORM != 0) ? {sign, 31'b0} : {sign, 8'h00, man_r[MAN_W-1:0]};
      end else begin
         z = {sign, 8'(exp_r + BIAS), man_r[MAN_W-1:0]};
      end
   end

endmodule

// File: rtl/fp_multiplier.sv
// ----------------------------------------------------------------------------
// fp_multiplier
//   Multi-cycle IEEE-754 single-precision multiplier with the same strobe
//   interface as the adder, so the two chain directly.
//   Ports:
//     clk           in  1   rising-edge clock
//     rst           in  1   asynchronous active-low reset
//     input_stb     in  1   operand-valid pulse, sampled only in IDLE
//     input_a       in  32  operand A
//     input_b       in  32  operand B
//     output_z      out 32  rounded product, held until the next result
//     output_z_stb  out 1   one-cycle pulse, output_z valid
//     busy          out 1   high from the cycle after capture to the strobe cycle
//   The strobe is registered on leaving OUT, so it appears 11 clocks after
//   capture for normal operands, 3 for specials, +1 per normalise/underflow
//   shift.
// ----------------------------------------------------------------------------
module fp_multiplier
   import fp32_pkg::*;
#(
   parameter int FLUSH_DENORM = 0
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        input_stb,
   input  logic [31:0] input_a,
   input  logic [31:0] input_b,
   output logic [31:0] output_z,
   output logic        output_z_stb,
   output logic        busy
);

   state_t      state_reg;
   logic [31:0] a_reg, b_reg;
   logic [23:0] m_a_reg, m_b_reg, m_reg;
   exp_t        exp_a_reg, exp_b_reg, exp_reg;
   logic        sign_reg;
   logic [47:0] prod_reg;
   logic        guard_reg, round_reg, sticky_reg;
   logic [31:0] z_reg;

   logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sign_ab;
   logic        is_special;
   logic [31:0] special_z;
   logic [31:0] rp_z;

   assign a_nan   = (&a_reg[30:23]) & (|a_reg[MAN_W-1:0]);
   assign b_nan   = (&b_reg[30:23]) & (|b_reg[MAN_W-1:0]);
   assign a_inf   = (&a_reg[30:23]) & ~(|a_reg[MAN_W-1:0]);
   assign b_inf   = (&b_reg[30:23]) & ~(|b_reg[MAN_W-1:0]);
   // Unpacked mantissa is zero for true zeros and for flushed denormals.
   assign a_zero  = (m_a_reg == '0);
   assign b_zero  = (m_b_reg == '0);
   assign sign_ab = a_reg[31] ^ b_reg[31];

   always_comb begin
      special_z  = '0;
      is_special = 1'b1;
      if (a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero))
         special_z = QNAN;
      else if (a_inf | b_inf)
         special_z = {sign_ab, POS_INF[30:0]};
      else if (a_zero | b_zero)
         special_z = {sign_ab, 31'b0};
      else
         is_special = 1'b0;
   end

   fp32_round_pack #(
      .FLUSH_DENORM (FLUSH_DENORM)
   ) u_round_pack (
      .man       (m_reg),
      .exp_in    (exp_reg),
      .sign      (sign_reg),
      .guard     (guard_reg),
      .round_bit (round_reg),
      .sticky    (sticky_reg),
      .z         (rp_z)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg    <= IDLE;
         a_reg        <= '0;
         b_reg        <= '0;
         m_a_reg      <= '0;
         m_b_reg      <= '0;
         m_reg        <= '0;
         exp_a_reg    <= '0;
         exp_b_reg    <= '0;
         exp_reg      <= '0;
         sign_reg     <= 1'b0;
         prod_reg     <= '0;
         guard_reg    <= 1'b0;
         round_reg    <= 1'b0;
         sticky_reg   <= 1'b0;
         z_reg        <= '0;
         output_z     <= '0;
         output_z_stb <= 1'b0;
         busy         <= 1'b0;
      end else begin
         output_z_stb <= 1'b0;
         case (state_reg)
            IDLE: begin
               busy <= 1'b0;
               if (input_stb) begin
                  a_reg     <= input_a;
                  b_reg     <= input_b;
                  busy      <= 1'b1;
                  state_reg <= UNPACK;
               end
            end
            UNPACK: begin
               exp_a_reg <= unbias(a_reg[30:23]);
               exp_b_reg <= unbias(b_reg[30:23]);
               m_a_reg   <= ((FLUSH_DENORM != 0) && (a_reg[30:23] == '0)) ? '0 :
                            {|a_reg[30:23], a_reg[MAN_W-1:0]};
               m_b_reg   <= ((FLUSH_DENORM != 0) && (b_reg[30:23] == '0)) ? '0 :
                            {|b_reg[30:23], b_reg[MAN_W-1:0]};
               state_reg <= SPECIAL;
            end
            SPECIAL: begin
               if (is_special) begin
                  z_reg     <= special_z;
                  state_reg <= OUT;
               end else begin
                  state_reg <= NORM_A;
               end
            end
            NORM_A: begin
               // Non-zero here, so the loop always terminates.
               if (!m_a_reg[23]) begin
                  m_a_reg   <= {m_a_reg[22:0], 1'b0};
                  exp_a_reg <= exp_a_reg - 10'sd1;
               end else begin
                  state_reg <= NORM_B;
               end
            end
            NORM_B: begin
               if (!m_b_reg[23]) begin
                  m_b_reg   <= {m_b_reg[22:0], 1'b0};
                  exp_b_reg <= exp_b_reg - 10'sd1;
               end else begin
                  state_reg <= MUL_0;
               end
            end
            MUL_0: begin
               prod_reg  <= {24'b0, m_a_reg} * {24'b0, m_b_reg};
               sign_reg  <= sign_ab;
               exp_reg   <= exp_a_reg + exp_b_reg + 10'sd1;
               state_reg <= MUL_1;
            end
            MUL_1: begin
               m_reg      <= prod_reg[47:24];
               guard_reg  <= prod_reg[23];
               round_reg  <= prod_reg[22];
               sticky_reg <= |prod_reg[21:0];
               state_reg  <= NORM_1;
            end
            NORM_1: begin
               // Both inputs are normalised, so one shift always suffices.
               if (!m_reg[23]) begin
                  m_reg     <= {m_reg[22:0], guard_reg};
                  guard_reg <= round_reg;
                  round_reg <= 1'b0;
                  exp_reg   <= exp_reg - 10'sd1;
               end
               state_reg <= NORM_2;
            end
            NORM_2: begin
               if (exp_reg < EMIN) begin
                  m_reg      <= {1'b0, m_reg[23:1]};
                  guard_reg  <= m_reg[0];
                  round_reg  <= guard_reg;
                  sticky_reg <= sticky_reg | round_reg;
                  exp_reg    <= exp_reg + 10'sd1;
               end else begin
                  state_reg <= ROUND;
               end
            end
            ROUND: begin
               // The round/pack core settles from stable registers here and
               // its word is captured in PACK.
               state_reg <= PACK;
            end
            PACK: begin
               z_reg     <= rp_z;
               state_reg <= OUT;
            end
            OUT: begin
               output_z     <= z_reg;
               output_z_stb <= 1'b1;
               state_reg    <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_multiplier.sv
// ----------------------------------------------------------------------------
// tb_fp_multiplier
//   Drives two multiplier instances (FLUSH_DENORM=0 and =1) with directed
//   operand pairs. Expected words and latencies are pushed to a scoreboard
//   queue when an operation is issued and popped when the strobe arrives.
// ----------------------------------------------------------------------------
module tb_fp_multiplier;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stb0 = 1'b0, stb1 = 1'b0;
   logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
   logic [31:0] z0, z1;
   logic        zs0, zs1, busy0, busy1;

   always #5 clk = ~clk;

   fp_multiplier #(.FLUSH_DENORM(0)) dut (
      .clk(clk), .rst(rst), .input_stb(stb0), .input_a(a0), .input_b(b0),
      .output_z(z0), .output_z_stb(zs0), .busy(busy0));

   fp_multiplier #(.FLUSH_DENORM(1)) dut_f (
      .clk(clk), .rst(rst), .input_stb(stb1), .input_a(a1), .input_b(b1),
      .output_z(z1), .output_z_stb(zs1), .busy(busy1));

   typedef struct {
      logic [31:0] z;
      int          lat;
   } exp_item_t;

   exp_item_t sb_q[$];
   int n_checks = 0;
   int n_fail   = 0;

   // Issue one pair on the selected instance once it is idle, then count
   // clocks from the capture edge to the strobe (-1 if it never comes).
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit f,
                         output logic [31:0] z, output int cyc);
      int wait_cnt;
      @(negedge clk);
      wait_cnt = 0;
      while ((f ? busy1 : busy0) && wait_cnt < 100) begin
         @(negedge clk);
         wait_cnt++;
      end
      if (f) begin a1 = a; b1 = b; stb1 = 1'b1; end
      else   begin a0 = a; b0 = b; stb0 = 1'b1; end
      @(posedge clk); #1;
      stb0 = 1'b0;
      stb1 = 1'b0;
      cyc = -1;
      z   = 'x;
      for (int i = 1; i <= 200; i++) begin
         @(posedge clk); #1;
         if (f ? zs1 : zs0) begin
            cyc = i;
            z   = f ? z1 : z0;
            break;
         end
      end
   endtask

   task automatic test_reset;
      #2 rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++; if (z0 !== 32'h0) begin n_fail++; $display("FAIL reset_z got %08h expected 00000000", z0); end
      n_checks++; if (zs0 !== 1'b0) begin n_fail++; $display("FAIL reset_stb got %b expected 0", zs0); end
      n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b expected 0", busy0); end
      n_checks++; if (z1 !== 32'h0 || zs1 !== 1'b0 || busy1 !== 1'b0) begin
         n_fail++; $display("FAIL reset_flush_inst got z=%08h stb=%b busy=%b expected 0/0/0", z1, zs1, busy1);
      end
      rst = 1'b1;
      $display("reset released");
   endtask

   task automatic test_basic;
      logic [31:0] z; int cyc; exp_item_t e;
      e.z = 32'h40c00000; e.lat = 11; sb_q.push_back(e);
      run_op(32'h40000000, 32'h40400000, 1'b0, z, cyc);
      e = sb_q.pop_front();
      $display("basic 40000000 x 40400000 -> %08h after %0d clocks", z, cyc);
      n_checks++; if (z !== e.z) begin n_fail++; $display("FAIL basic_value got %08h expected %08h", z, e.z); end
      n_checks++; if (cyc != e.lat) begin n_fail++; $display("FAIL basic_latency got %0d expected %0d", cyc, e.lat); end
      n_checks++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL basic_busy_in_strobe got %b expected 1", busy0); end
      @(posedge clk); #1;
      n_checks++; if (busy0 !== 1'b0 || zs0 !== 1'b0) begin
         n_fail++; $display("FAIL basic_after_strobe got busy=%b stb=%b expected 0/0", busy0, zs0);
      end
   endtask

   task automatic test_arith;
      logic [31:0] va [4]; logic [31:0] vb [4]; logic [31:0] vz [4]; int vl [4];
      logic [31:0] z; int cyc; exp_item_t e;
      va[0] = 32'hbfc00000; vb[0] = 32'h40800000; vz[0] = 32'hc0c00000; vl[0] = 11;
      va[1] = 32'h3f800001; vb[1] = 32'h3f800001; vz[1] = 32'h3f800002; vl[1] = 11;
      va[2] = 32'h7f7fffff; vb[2] = 32'h40000000; vz[2] = 32'h7f800000; vl[2] = 11;
      va[3] = 32'h00800000; vb[3] = 32'h3f000000; vz[3] = 32'h00400000; vl[3] = 12;
      for (int i = 0; i < 4; i++) begin
         e.z = vz[i]; e.lat = vl[i]; sb_q.push_back(e);
         run_op(va[i], vb[i], 1'b0, z, cyc);
         e = sb_q.pop_front();
         $display("arith %08h x %08h -> %08h after %0d clocks", va[i], vb[i], z, cyc);
         n_checks++; if (z !== e.z) begin n_fail++; $display("FAIL arith_value[%0d] got %08h expected %08h", i, z, e.z); end
         n_checks++; if (cyc != e.lat) begin n_fail++; $display("FAIL arith_latency[%0d] got %0d expected %0d", i, cyc, e.lat); end
      end
   endtask

   task automatic test_special;
      logic [31:0] va [4]; logic [31:0] vb [4]; logic [31:0] vz [4];
      logic [31:0] z; int cyc; exp_item_t e;
      va[0] = 32'h7f800000; vb[0] = 32'h00000000; vz[0] = 32'h7fc00000;
      va[1] = 32'hff800000; vb[1] = 32'h40000000; vz[1] = 32'hff800000;
      va[2] = 32'h7fc00001; vb[2] = 32'h3f800000; vz[2] = 32'h7fc00000;
      va[3] = 32'h80000000; vb[3] = 32'h3f800000; vz[3] = 32'h80000000;
      for (int i = 0; i < 4; i++) begin
         e.z = vz[i]; e.lat = 3; sb_q.push_back(e);
         run_op(va[i], vb[i], 1'b0, z, cyc);
         e = sb_q.pop_front();
         $display("special %08h x %08h -> %08h after %0d clocks", va[i], vb[i], z, cyc);
         n_checks++; if (z !== e.z) begin n_fail++; $display("FAIL special_value[%0d] got %08h expected %08h", i, z, e.z); end
         n_checks++; if (cyc != e.lat) begin n_fail++; $display("FAIL special_latency[%0d] got %0d expected %0d", i, cyc, e.lat); end
      end
   endtask

   task automatic test_flush;
      logic [31:0] z; int cyc; exp_item_t e;
      // 2^-149 x 2^23: 23 normalise shifts on the denormal operand.
      e.z = 32'h00800000; e.lat = 34; sb_q.push_back(e);
      run_op(32'h00000001, 32'h4b000000, 1'b0, z, cyc);
      e = sb_q.pop_front();
      $display("denorm keep 00000001 x 4b000000 -> %08h after %0d clocks", z, cyc);
      n_checks++; if (z !== e.z) begin n_fail++; $display("FAIL denorm_value got %08h expected %08h", z, e.z); end
      n_checks++; if (cyc != e.lat) begin n_fail++; $display("FAIL denorm_latency got %0d expected %0d", cyc, e.lat); end
      e.z = 32'h00000000; e.lat = 3; sb_q.push_back(e);
      run_op(32'h00000001, 32'h4b000000, 1'b1, z, cyc);
      e = sb_q.pop_front();
      $display("denorm flush 00000001 x 4b000000 -> %08h after %0d clocks", z, cyc);
      n_checks++; if (z !== e.z) begin n_fail++; $display("FAIL flush_value got %08h expected %08h", z, e.z); end
      n_checks++; if (cyc != e.lat) begin n_fail++; $display("FAIL flush_latency got %0d expected %0d", cyc, e.lat); end
   endtask

   task automatic test_back_to_back;
      logic [31:0] va [3]; logic [31:0] vb [3]; logic [31:0] vz [3]; int vl [3];
      logic [31:0] z; int cyc; exp_item_t e;
      va[0] = 32'h3f800000; vb[0] = 32'h3f800000; vz[0] = 32'h3f800000; vl[0] = 11;
      va[1] = 32'h00800000; vb[1] = 32'h3f000000; vz[1] = 32'h00000000; vl[1] = 12;
      va[2] = 32'h40000000; vb[2] = 32'h40400000; vz[2] = 32'h40c00000; vl[2] = 11;
      for (int i = 0; i < 3; i++) begin
         e.z = vz[i]; e.lat = vl[i]; sb_q.push_back(e);
         run_op(va[i], vb[i], 1'b1, z, cyc);
         e = sb_q.pop_front();
         $display("b2b flush-inst %08h x %08h -> %08h after %0d clocks", va[i], vb[i], z, cyc);
         n_checks++; if (z !== e.z) begin n_fail++; $display("FAIL b2b_value[%0d] got %08h expected %08h", i, z, e.z); end
         n_checks++; if (cyc != e.lat) begin n_fail++; $display("FAIL b2b_latency[%0d] got %0d expected %0d", i, cyc, e.lat); end
      end
   endtask

   task automatic test_abort;
      logic [31:0] z; int cyc; int seen; exp_item_t e;
      @(negedge clk);
      a0 = 32'h40400000; b0 = 32'h3f000000; stb0 = 1'b1;
      @(posedge clk); #1 stb0 = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_checks++; if (z0 !== 32'h0 || zs0 !== 1'b0 || busy0 !== 1'b0) begin
         n_fail++; $display("FAIL abort_reset_outputs got z=%08h stb=%b busy=%b expected 0/0/0", z0, zs0, busy0);
      end
      @(negedge clk);
      rst = 1'b1;
      seen = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (zs0) seen++;
      end
      $display("abort: %0d strobes after reset", seen);
      n_checks++; if (seen != 0) begin n_fail++; $display("FAIL abort_no_strobe got %0d expected 0", seen); end

      // Re-issue; a second pulse 4 clocks in must be ignored.
      e.z = 32'h3fc00000; e.lat = 11; sb_q.push_back(e);
      @(negedge clk);
      a0 = 32'h40400000; b0 = 32'h3f000000; stb0 = 1'b1;
      @(posedge clk); #1 stb0 = 1'b0;
      cyc = -1; z = 'x;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (i == 4) begin a0 = 32'h40000000; b0 = 32'h40000000; stb0 = 1'b1; end
         else stb0 = 1'b0;
         @(posedge clk); #1;
         if (zs0) begin cyc = i; z = z0; break; end
      end
      stb0 = 1'b0;
      e = sb_q.pop_front();
      $display("reissue 40400000 x 3f000000 -> %08h after %0d clocks", z, cyc);
      n_checks++; if (z !== e.z) begin n_fail++; $display("FAIL reissue_value got %08h expected %08h", z, e.z); end
      n_checks++; if (cyc != e.lat) begin n_fail++; $display("FAIL reissue_latency got %0d expected %0d", cyc, e.lat); end
      seen = 0;
      repeat (16) begin
         @(posedge clk); #1;
         if (zs0) seen++;
      end
      n_checks++; if (seen != 0) begin n_fail++; $display("FAIL busy_pulse_ignored got %0d extra strobes expected 0", seen); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_arith();
      test_special();
      test_flush();
      test_back_to_back();
      test_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired at %0t, expected test to complete", $time);
      $fatal(1, "watchdog");
   end

endmodule
